// File: rtl/synaptic_update_ctrl.sv
// Learning-phase sequencer for the synaptic/gradient SRAM banks: sweeps every synaptic word
// with a read, calc (TREF) and write-back step, and drives the core's CTRL_* port.
module synaptic_update_ctrl #(
    parameter int unsigned INPUT_NEURON         = 784,
    parameter int unsigned OUTPUT_NEURON        = 256,
    parameter int unsigned POST_NEUR_PARALLEL   = 4,
    parameter int unsigned PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int unsigned POST_NEUR_ADDR_WIDTH = 10,
    parameter int unsigned SYN_ARRAY_ADDR_WIDTH = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic                            UPDATE_MODE,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            CTRL_SYNARRAY_CS,
    output logic                            CTRL_SYNARRAY_WE,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
    output logic                            CTRL_GRAD_ARRAY_CS,
    output logic                            CTRL_GRAD_ARRAY_WE,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
    output logic                            CTRL_TREF_EVENT
);

    localparam int unsigned WPP     = OUTPUT_NEURON / POST_NEUR_PARALLEL;
    localparam int unsigned N_WORDS = INPUT_NEURON * WPP;

    localparam logic [SYN_ARRAY_ADDR_WIDTH-1:0] LAST_ADDR =
        SYN_ARRAY_ADDR_WIDTH'(N_WORDS - 1);
    localparam logic [POST_NEUR_ADDR_WIDTH-1:0] POST_LAST =
        POST_NEUR_ADDR_WIDTH'(OUTPUT_NEURON - POST_NEUR_PARALLEL);
    localparam logic [POST_NEUR_ADDR_WIDTH-1:0] POST_STEP =
        POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);

    typedef enum logic [2:0] {StIdle, StRead, StCalc, StWrite, StDone} state_e;

    state_e state_q;
    logic   mode_q;

    // Outputs are set on the edge that enters each state, so every port is a flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q                  <= StIdle;
            mode_q                   <= 1'b0;
            BUSY                     <= 1'b0;
            DONE                     <= 1'b0;
            CTRL_SYNARRAY_CS         <= 1'b0;
            CTRL_SYNARRAY_WE         <= 1'b0;
            CTRL_SYNARRAY_ADDR       <= '0;
            CTRL_GRAD_ARRAY_CS       <= 1'b0;
            CTRL_GRAD_ARRAY_WE       <= 1'b0;
            CTRL_PRE_NEURON_ADDRESS  <= '0;
            CTRL_POST_NEURON_ADDRESS <= '0;
            CTRL_TREF_EVENT          <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (START) begin
                        state_q                  <= StRead;
                        mode_q                   <= UPDATE_MODE;
                        BUSY                     <= 1'b1;
                        CTRL_SYNARRAY_CS         <= 1'b1;
                        CTRL_GRAD_ARRAY_CS       <= 1'b1;
                        CTRL_SYNARRAY_ADDR       <= '0;
                        CTRL_PRE_NEURON_ADDRESS  <= '0;
                        CTRL_POST_NEURON_ADDRESS <= '0;
                    end
                end
                StRead: begin
                    state_q            <= StCalc;
                    CTRL_SYNARRAY_CS   <= 1'b0;
                    CTRL_GRAD_ARRAY_CS <= 1'b0;
                    CTRL_TREF_EVENT    <= 1'b1;
                end
                StCalc: begin
                    state_q            <= StWrite;
                    CTRL_TREF_EVENT    <= 1'b0;
                    CTRL_SYNARRAY_CS   <= 1'b1;
                    CTRL_GRAD_ARRAY_CS <= 1'b1;
                    CTRL_GRAD_ARRAY_WE <= 1'b1;
                    CTRL_SYNARRAY_WE   <= mode_q;
                end
                StWrite: begin
                    CTRL_SYNARRAY_WE   <= 1'b0;
                    CTRL_GRAD_ARRAY_WE <= 1'b0;
                    if (CTRL_SYNARRAY_ADDR == LAST_ADDR) begin
                        state_q            <= StDone;
                        CTRL_SYNARRAY_CS   <= 1'b0;
                        CTRL_GRAD_ARRAY_CS <= 1'b0;
                        BUSY               <= 1'b0;
                        DONE               <= 1'b1;
                    end else begin
                        // CS stays high: the next READ follows the write back-to-back.
                        state_q            <= StRead;
                        CTRL_SYNARRAY_ADDR <= CTRL_SYNARRAY_ADDR + SYN_ARRAY_ADDR_WIDTH'(1);
                        if (CTRL_POST_NEURON_ADDRESS == POST_LAST) begin
                            CTRL_POST_NEURON_ADDRESS <= '0;
                            CTRL_PRE_NEURON_ADDRESS  <=
                                CTRL_PRE_NEURON_ADDRESS + PRE_NEUR_ADDR_WIDTH'(1);
                        end else begin
                            CTRL_POST_NEURON_ADDRESS <= CTRL_POST_NEURON_ADDRESS + POST_STEP;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    DONE    <= 1'b0;
                end
                default: begin
                    state_q            <= StIdle;
                    BUSY               <= 1'b0;
                    DONE               <= 1'b0;
                    CTRL_SYNARRAY_CS   <= 1'b0;
                    CTRL_SYNARRAY_WE   <= 1'b0;
                    CTRL_GRAD_ARRAY_CS <= 1'b0;
                    CTRL_GRAD_ARRAY_WE <= 1'b0;
                    CTRL_TREF_EVENT    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
// Directed bench for synaptic_update_ctrl on a small 3x8 (WPP=2, N=6) configuration.
module tb_synaptic_update_ctrl;

    localparam int unsigned IN_N = 3;
    localparam int unsigned OUT_N = 8;
    localparam int unsigned PAR = 4;
    localparam int unsigned WPP = OUT_N / PAR;
    localparam int unsigned NW = IN_N * WPP;

    logic        CLK, RST, START, UPDATE_MODE;
    logic        BUSY, DONE, syn_cs, syn_we, grad_cs, grad_we, tref;
    logic [15:0] addr;
    logic [9:0]  pre, post;

    int tests = 0;
    int fails = 0;
    int syn_we_cnt, grad_we_cnt, done_cnt;

    synaptic_update_ctrl #(
        .INPUT_NEURON(IN_N),
        .OUTPUT_NEURON(OUT_N),
        .POST_NEUR_PARALLEL(PAR),
        .PRE_NEUR_ADDR_WIDTH(10),
        .POST_NEUR_ADDR_WIDTH(10),
        .SYN_ARRAY_ADDR_WIDTH(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .UPDATE_MODE(UPDATE_MODE),
        .BUSY(BUSY),
        .DONE(DONE),
        .CTRL_SYNARRAY_CS(syn_cs),
        .CTRL_SYNARRAY_WE(syn_we),
        .CTRL_SYNARRAY_ADDR(addr),
        .CTRL_GRAD_ARRAY_CS(grad_cs),
        .CTRL_GRAD_ARRAY_WE(grad_we),
        .CTRL_PRE_NEURON_ADDRESS(pre),
        .CTRL_POST_NEURON_ADDRESS(post),
        .CTRL_TREF_EVENT(tref)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] flags();
        return {BUSY, DONE, syn_cs, syn_we, grad_cs, grad_we, tref};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, 32'(flags()), 32'd0);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_pre"}, 32'(pre), 32'd0);
        chk({tag, "_post"}, 32'(post), 32'd0);
    endtask

    // Call at the negedge of cycle 0 with START just raised; returns at the negedge of
    // cycle 20 (first IDLE cycle). START drops at cycle drop_at.
    task automatic sweep(input logic mode, input bit toggle, input int drop_at);
        logic [6:0] ef;
        int k, ph;
        syn_we_cnt = 0;
        grad_we_cnt = 0;
        for (int cyc = 1; cyc <= 3 * NW + 2; cyc++) begin
            @(negedge CLK);
            if (syn_we) syn_we_cnt++;
            if (grad_we) grad_we_cnt++;
            if (cyc <= 3 * NW) begin
                k = (cyc - 1) / 3;
                ph = (cyc - 1) % 3;
                // {busy, done, syn_cs, syn_we, grad_cs, grad_we, tref}
                ef = {1'b1, 1'b0, ph != 1, (ph == 2) && mode, ph != 1, ph == 2, ph == 1};
                chk($sformatf("c%0d_flags", cyc), 32'(flags()), 32'(ef));
                chk($sformatf("c%0d_addr", cyc), 32'(addr), 32'(k));
                chk($sformatf("c%0d_pre", cyc), 32'(pre), 32'(k / WPP));
                chk($sformatf("c%0d_post", cyc), 32'(post), 32'((k % WPP) * PAR));
            end else if (cyc == 3 * NW + 1) begin
                chk("done_flags", 32'(flags()), 32'b0100000);
                chk("done_addr", 32'(addr), 32'(NW - 1));
                chk("done_pre", 32'(pre), 32'(IN_N - 1));
                chk("done_post", 32'(post), 32'((WPP - 1) * PAR));
            end else begin
                chk("idle_flags", 32'(flags()), 32'd0);
            end
            if (cyc == drop_at) START = 1'b0;
            if (toggle) UPDATE_MODE = ~UPDATE_MODE;
        end
        chk("grad_we_pulses", 32'(grad_we_cnt), 32'(NW));
        chk("syn_we_pulses", 32'(syn_we_cnt), mode ? 32'(NW) : 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        UPDATE_MODE = 1'b0;
        repeat (2) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_no_start", 32'(flags()), 32'd0);

        // Apply mode sweep
        START = 1'b1;
        UPDATE_MODE = 1'b1;
        sweep(1'b1, 1'b0, 1);

        // Accumulate mode with UPDATE_MODE toggling every cycle
        @(negedge CLK);
        START = 1'b1;
        UPDATE_MODE = 1'b0;
        sweep(1'b0, 1'b1, 1);

        // START held high 30 cycles: back-to-back sweeps, second accepted in cycle 20
        @(negedge CLK);
        START = 1'b1;
        UPDATE_MODE = 1'b1;
        sweep(1'b1, 1'b0, 100);
        sweep(1'b1, 1'b0, 10);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (BUSY || DONE) done_cnt++;
        end
        chk("no_third_sweep", 32'(done_cnt), 32'd0);

        // Async reset mid-CALC of word 3 (cycle 11)
        START = 1'b1;
        UPDATE_MODE = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) START = 1'b0;
        end
        chk("pre_rst_tref", 32'(tref), 32'd1);
        chk("pre_rst_addr", 32'(addr), 32'd3);
        #2 RST = 1'b1;
        #1 chk_all_zero("async_rst");
        done_cnt = 0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE || BUSY) done_cnt++;
        end
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk_all_zero("post_rst_idle");
        START = 1'b1;
        sweep(1'b1, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
